starterkit_seg_scanner: RTL and testbench



---
 rtl/starterkit_seg_scanner.sv | 175 +++++++++++++++++
 tb/tb_starterkit_seg_scanner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/starterkit_seg_scanner.sv
// Multiplexed N-digit 7-segment scanner with per-frame input shadowing,
// hex or raw segment source, PWM brightness, per-digit blink and pin polarity.
module starterkit_seg_scanner #(
    parameter int C_DIGITS           = 4,
    parameter int C_SCAN_DIV         = 1024,
    parameter int C_BRIGHT_BITS      = 4,
    parameter int C_BLINK_FRAMES     = 64,
    parameter int C_SEG_ACTIVE_LOW   = 0,
    parameter int C_DIGIT_ACTIVE_LOW = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     MODE,
    input  logic [4*C_DIGITS-1:0]    DATA,
    input  logic [C_DIGITS-1:0]      DP,
    input  logic [8*C_DIGITS-1:0]    RAW,
    input  logic [C_DIGITS-1:0]      BLINK,
    input  logic [C_BRIGHT_BITS-1:0] BRIGHT,
    output logic [7:0]               SEG_pins,
    output logic [C_DIGITS-1:0]      DIGIT_pins,
    output logic                     FRAME
);

    localparam int SW = (C_SCAN_DIV > 1) ? $clog2(C_SCAN_DIV) : 1;
    localparam int DW = (C_DIGITS > 1) ? $clog2(C_DIGITS) : 1;
    localparam int FW = (C_BLINK_FRAMES > 1) ? $clog2(C_BLINK_FRAMES) : 1;
    localparam logic [31:0]   STEP    = 32'(C_SCAN_DIV >> C_BRIGHT_BITS);
    localparam logic [SW-1:0] S_LAST  = SW'(C_SCAN_DIV - 1);
    localparam logic [DW-1:0] D_LAST  = DW'(C_DIGITS - 1);
    localparam logic [FW-1:0] F_LAST  = FW'(C_BLINK_FRAMES - 1);
    localparam logic          SEG_INV = (C_SEG_ACTIVE_LOW != 0);
    localparam logic          DIG_INV = (C_DIGIT_ACTIVE_LOW != 0);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [SW-1:0]            s_q, s_d;
    logic [DW-1:0]            d_q, d_d;
    logic [FW-1:0]            frm_q, frm_d;
    logic                     blink_q, blink_d;
    logic                     sh_mode_q, sh_mode_d;
    logic [4*C_DIGITS-1:0]    sh_data_q, sh_data_d;
    logic [C_DIGITS-1:0]      sh_dp_q, sh_dp_d;
    logic [8*C_DIGITS-1:0]    sh_raw_q, sh_raw_d;
    logic [C_DIGITS-1:0]      sh_blink_q, sh_blink_d;
    logic [C_BRIGHT_BITS-1:0] sh_bright_q, sh_bright_d;
    logic [7:0]               seg_q, seg_d;
    logic [C_DIGITS-1:0]      dig_q, dig_d;
    logic                     frame_q, frame_d;

    logic                     s_wrap, d_wrap, f_wrap, active;
    logic [31:0]              lim;
    logic [7:0]               seg_byte;

    always_comb begin
        s_d         = s_q;
        d_d         = d_q;
        frm_d       = frm_q;
        blink_d     = blink_q;
        sh_mode_d   = sh_mode_q;
        sh_data_d   = sh_data_q;
        sh_dp_d     = sh_dp_q;
        sh_raw_d    = sh_raw_q;
        sh_blink_d  = sh_blink_q;
        sh_bright_d = sh_bright_q;
        seg_d       = {8{SEG_INV}};
        dig_d       = {C_DIGITS{DIG_INV}};
        frame_d     = 1'b0;

        s_wrap = (s_q == S_LAST);
        d_wrap = (d_q == D_LAST);
        f_wrap = (frm_q == F_LAST);

        // Brightness window: s==0 is always a ghosting blank, then (BRIGHT+1)*STEP-1 lit cycles.
        lim    = (32'(sh_bright_q) + 32'd1) * STEP;
        active = EN && (s_q != '0) && (32'(s_q) < lim) && !(sh_blink_q[d_q] && blink_q);

        if (sh_mode_q) begin
            seg_byte = sh_raw_q[{d_q, 3'b000} +: 8];
        end else begin
            seg_byte = {sh_dp_q[d_q], hex7(sh_data_q[{d_q, 2'b00} +: 4])};
        end

        // Frame start: capture every display input so the whole frame is tear-free.
        if (s_q == '0 && d_q == '0) begin
            sh_mode_d   = MODE;
            sh_data_d   = DATA;
            sh_dp_d     = DP;
            sh_raw_d    = RAW;
            sh_blink_d  = BLINK;
            sh_bright_d = BRIGHT;
        end

        if (!EN) begin
            s_d     = '0;
            d_d     = '0;
            frm_d   = '0;
            blink_d = 1'b0;
        end else begin
            frame_d = s_wrap && d_wrap;
            if (s_wrap) begin
                s_d = '0;
                if (d_wrap) begin
                    d_d     = '0;
                    frm_d   = f_wrap ? '0 : frm_q + 1'b1;
                    blink_d = blink_q ^ f_wrap;
                end else begin
                    d_d = d_q + 1'b1;
                end
            end else begin
                s_d = s_q + 1'b1;
            end
            if (active) begin
                seg_d = seg_byte ^ {8{SEG_INV}};
                dig_d = (C_DIGITS'(1) << d_q) ^ {C_DIGITS{DIG_INV}};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s_q         <= '0;
            d_q         <= '0;
            frm_q       <= '0;
            blink_q     <= 1'b0;
            sh_mode_q   <= 1'b0;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_raw_q    <= '0;
            sh_blink_q  <= '0;
            sh_bright_q <= '0;
            seg_q       <= {8{SEG_INV}};
            dig_q       <= {C_DIGITS{DIG_INV}};
            frame_q     <= 1'b0;
        end else begin
            s_q         <= s_d;
            d_q         <= d_d;
            frm_q       <= frm_d;
            blink_q     <= blink_d;
            sh_mode_q   <= sh_mode_d;
            sh_data_q   <= sh_data_d;
            sh_dp_q     <= sh_dp_d;
            sh_raw_q    <= sh_raw_d;
            sh_blink_q  <= sh_blink_d;
            sh_bright_q <= sh_bright_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
            frame_q     <= frame_d;
        end
    end

    assign SEG_pins   = seg_q;
    assign DIGIT_pins = dig_q;
    assign FRAME      = frame_q;

endmodule

// File: tb/tb_starterkit_seg_scanner.sv
// Bench for starterkit_seg_scanner: an active-high and an active-low instance
// share stimulus and are checked every cycle against a cycle-count based model.
module tb_starterkit_seg_scanner;

    localparam int DIG  = 4;
    localparam int DIV  = 16;
    localparam int BB   = 2;
    localparam int BF   = 2;
    localparam int STEP = DIV >> BB;

    logic        CLK = 1'b0;
    logic        RST, EN, MODE;
    logic [15:0] DATA;
    logic [3:0]  DP, BLINK;
    logic [31:0] RAW;
    logic [1:0]  BRIGHT;
    logic [7:0]  seg_hi, seg_lo;
    logic [3:0]  dig_hi, dig_lo;
    logic        fr_hi, fr_lo;

    always #5 CLK = ~CLK;

    starterkit_seg_scanner #(
        .C_DIGITS(DIG), .C_SCAN_DIV(DIV), .C_BRIGHT_BITS(BB), .C_BLINK_FRAMES(BF),
        .C_SEG_ACTIVE_LOW(0), .C_DIGIT_ACTIVE_LOW(0)
    ) u_hi (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DATA(DATA), .DP(DP), .RAW(RAW),
        .BLINK(BLINK), .BRIGHT(BRIGHT), .SEG_pins(seg_hi), .DIGIT_pins(dig_hi), .FRAME(fr_hi)
    );

    starterkit_seg_scanner #(
        .C_DIGITS(DIG), .C_SCAN_DIV(DIV), .C_BRIGHT_BITS(BB), .C_BLINK_FRAMES(BF),
        .C_SEG_ACTIVE_LOW(1), .C_DIGIT_ACTIVE_LOW(1)
    ) u_lo (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DATA(DATA), .DP(DP), .RAW(RAW),
        .BLINK(BLINK), .BRIGHT(BRIGHT), .SEG_pins(seg_lo), .DIGIT_pins(dig_lo), .FRAME(fr_lo)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: position in the scan is derived from a plain cycle count n.
    byte unsigned hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                   8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    int          n_m = 0;
    logic        checking = 1'b0;
    logic [7:0]  e_seg, e_seg_lo;
    logic [3:0]  e_dig, e_dig_lo;
    logic        e_fr;
    logic        sh_mode;
    logic [15:0] sh_data;
    logic [3:0]  sh_dp, sh_blink;
    logic [31:0] sh_raw;
    logic [1:0]  sh_br;

    always @(posedge CLK) begin
        int s, d, f;
        logic act;
        logic [7:0] b;
        if (RST) begin
            checking = 1'b1;
            n_m = 0;
            sh_mode = 1'b0; sh_data = '0; sh_dp = '0; sh_raw = '0; sh_blink = '0; sh_br = '0;
            e_seg = 8'h00; e_dig = 4'h0; e_fr = 1'b0;
        end else if (!EN) begin
            n_m = 0;
            e_seg = 8'h00; e_dig = 4'h0; e_fr = 1'b0;
        end else begin
            s = n_m % DIV;
            d = (n_m / DIV) % DIG;
            f = n_m / (DIV * DIG);
            if (n_m % (DIV * DIG) == 0) begin
                sh_mode = MODE; sh_data = DATA; sh_dp = DP; sh_raw = RAW;
                sh_blink = BLINK; sh_br = BRIGHT;
            end
            act = (s >= 1) && (s < (int'(sh_br) + 1) * STEP) && !(sh_blink[d] && ((f / BF) % 2 == 1));
            if (sh_mode) b = sh_raw[8*d +: 8];
            else         b = hex_tab[sh_data[4*d +: 4]] | (sh_dp[d] ? 8'h80 : 8'h00);
            e_seg = act ? b : 8'h00;
            e_dig = act ? 4'(1 << d) : 4'h0;
            e_fr  = (s == DIV - 1) && (d == DIG - 1);
            n_m++;
        end
        e_seg_lo = ~e_seg;
        e_dig_lo = ~e_dig;
    end

    always @(negedge CLK) begin
        if (checking) begin
            chk("hi_seg", 32'(seg_hi), 32'(e_seg));
            chk("hi_dig", 32'(dig_hi), 32'(e_dig));
            chk("hi_frame", 32'(fr_hi), 32'(e_fr));
            chk("lo_seg", 32'(seg_lo), 32'(e_seg_lo));
            chk("lo_dig", 32'(dig_lo), 32'(e_dig_lo));
            chk("lo_frame", 32'(fr_lo), 32'(e_fr));
        end
    end

    int t = 0;

    task automatic goto(input int k);
        while (t < k) begin
            @(posedge CLK);
            t++;
        end
        #2;
    endtask

    task automatic lit_hi(input string name, input logic [7:0] s, input logic [3:0] d);
        chk({name, "_seg"}, 32'(seg_hi), 32'(s));
        chk({name, "_dig"}, 32'(dig_hi), 32'(d));
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; MODE = 1'b0; DATA = 16'h1234; DP = '0; RAW = '0;
        BLINK = '0; BRIGHT = 2'd3;
        repeat (2) @(posedge CLK);
        #2;
        lit_hi("reset", 8'h00, 4'h0);
        chk("reset_frame", 32'(fr_hi), 32'd0);
        chk("reset_lo_seg", 32'(seg_lo), 32'hFF);
        chk("reset_lo_dig", 32'(dig_lo), 32'hF);
        RST = 1'b0; EN = 1'b1; t = 0;

        // Hex scan at full brightness.
        goto(1);  lit_hi("blank_d0", 8'h00, 4'h0);
        goto(2);  lit_hi("d0_first", 8'h66, 4'h1);
        goto(16); lit_hi("d0_last", 8'h66, 4'h1);
        goto(17); lit_hi("blank_d1", 8'h00, 4'h0);
        goto(18); lit_hi("d1", 8'h4F, 4'h2);
        goto(34); lit_hi("d2", 8'h5B, 4'h4);
        goto(50); lit_hi("d3", 8'h06, 4'h8);
        goto(63); chk("frame_pre", 32'(fr_hi), 32'd0);
        goto(64); chk("frame_pulse", 32'(fr_hi), 32'd1);
        goto(65); chk("frame_post", 32'(fr_hi), 32'd0);

        // Minimum brightness from frame 2.
        goto(100); BRIGHT = 2'd0;
        goto(130); lit_hi("dim_s1", 8'h66, 4'h1);
        goto(132); lit_hi("dim_s3", 8'h66, 4'h1);
        goto(133); lit_hi("dim_s4", 8'h00, 4'h0);

        // Data change mid-frame stays hidden until the next frame.
        goto(150); DATA = 16'hABCD;
        goto(162); lit_hi("tear_d2", 8'h5B, 4'h4);
        goto(178); lit_hi("tear_d3", 8'h06, 4'h8);
        goto(194); lit_hi("new_d0", 8'h5E, 4'h1);
        goto(210); lit_hi("new_d1", 8'h39, 4'h2);

        // Blink on digit0: frames 4-5 visible, 6-7 blank, 8 visible.
        goto(220); BLINK = 4'b0001;
        goto(258); lit_hi("blink_on", 8'h5E, 4'h1);
        goto(386); lit_hi("blink_off", 8'h00, 4'h0);
        goto(402); lit_hi("blink_other", 8'h39, 4'h2);
        goto(514); lit_hi("blink_back", 8'h5E, 4'h1);

        // Raw mode, checked on the active-low instance.
        goto(520); MODE = 1'b1; RAW = 32'h0080_0000;
        goto(609);
        chk("raw_idle_seg", 32'(seg_lo), 32'hFF);
        chk("raw_idle_dig", 32'(dig_lo), 32'hF);
        goto(610);
        chk("raw_lo_seg", 32'(seg_lo), 32'h7F);
        chk("raw_lo_dig", 32'(dig_lo), 32'hB);

        // Reset pulse during digit2.
        goto(675); MODE = 1'b0; DATA = 16'h5678; RST = 1'b1;
        goto(676);
        lit_hi("rst_mid", 8'h00, 4'h0);
        chk("rst_mid_lo_seg", 32'(seg_lo), 32'hFF);
        RST = 1'b0; t = 0;
        goto(1); lit_hi("rst_blank", 8'h00, 4'h0);
        goto(2); lit_hi("rst_restart", 8'h7F, 4'h1);

        // Enable low for five cycles.
        goto(40); EN = 1'b0;
        goto(45); lit_hi("en_low", 8'h00, 4'h0);
        chk("en_low_frame", 32'(fr_hi), 32'd0);
        EN = 1'b1; t = 0;
        goto(2); lit_hi("en_restart", 8'h7F, 4'h1);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            @(posedge CLK);
            #2;
            if ($urandom_range(0, 7) == 0) DATA = 16'($urandom);
            if ($urandom_range(0, 7) == 0) RAW = $urandom;
            if ($urandom_range(0, 7) == 0) DP = 4'($urandom);
            if ($urandom_range(0, 31) == 0) MODE = 1'($urandom);
            if ($urandom_range(0, 31) == 0) BLINK = 4'($urandom);
            if ($urandom_range(0, 31) == 0) BRIGHT = 2'($urandom);
            EN  = ($urandom_range(0, 199) != 0);
            RST = ($urandom_range(0, 399) == 0);
        end
        @(posedge CLK);
        #2;
        RST = 1'b0; EN = 1'b1;
        repeat (3) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
